pmem_responder: RTL

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pmem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pmem_responder.sv
// pmem_responder: behavioural line-memory model answering cache-line reads and
// writes after a fixed latency. Holds 2**INDEX_BITS lines of 128 bits.
//
// Parameters:
//   LATENCY    cycles from request acceptance to pmem_resp (1..15)
//   INDEX_BITS line-index width; index = pmem_address[3+INDEX_BITS:4]
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset (clears state and all lines)
//   pmem_read    line read request, held until pmem_resp
//   pmem_write   line write request, held until pmem_resp (wins over read)
//   pmem_address byte address; low nibble ignored, upper bits alias
//   pmem_wdata   write line, word 0 at [15:0]
//   pmem_rdata   registered read line, held until the next read completes
//   pmem_resp    one-cycle completion pulse
//   pmem_error   sticky protocol-violation flag (only with PMEM_PROTOCOL_CHECK_EN)
//
// Optional feature: define PMEM_PROTOCOL_CHECK_EN to add pmem_error.
module pmem_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp
`ifdef PMEM_PROTOCOL_CHECK_EN
    ,
    output logic         pmem_error
`endif
);

    localparam int unsigned LINES  = 1 << INDEX_BITS;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [INDEX_BITS-1:0]   idx_q;
    logic [127:0]            wdata_q;
    logic                    is_write_q;
    logic [127:0]            rdata_q;
    logic                    resp_q;
    logic [127:0]            mem_q [LINES];

    logic [INDEX_BITS-1:0]   idx_d;
    logic                    req_d;
    logic                    unused_addr;

    assign idx_d       = pmem_address[3+INDEX_BITS:4];
    assign req_d       = pmem_read | pmem_write;
    // Low nibble and aliasing upper bits do not select anything.
    assign unused_addr = ^pmem_address;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= 1'b0;
            for (int unsigned i = 0; i < LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (req_d) begin
                        idx_q      <= idx_d;
                        wdata_q    <= pmem_wdata;
                        is_write_q <= pmem_write;
                        cnt_q      <= LAT_M1;
                        if (LATENCY == 1) begin
                            // Single-cycle latency skips BUSY, so the read
                            // line is fetched straight from the live index.
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            if (!pmem_write) begin
                                rdata_q <= mem_q[idx_d];
                            end
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!req_d) begin
                        // Requester withdrew: abandon without response or commit.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            if (!is_write_q) begin
                                rdata_q <= mem_q[idx_q];
                            end
                        end
                    end
                end
                RESP: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                    if (is_write_q) begin
                        mem_q[idx_q] <= wdata_q;
                    end
                end
                default: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = resp_q;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic       err_q;
    logic [1:0] ops_q;

    // ops_q remembers the request lines seen at acceptance; any difference
    // during BUSY (including both dropping) is a violation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            ops_q <= '0;
        end else begin
            if (state_q == IDLE && req_d) begin
                ops_q <= {pmem_read, pmem_write};
                if (pmem_read && pmem_write) begin
                    err_q <= 1'b1;
                end
            end
            if (state_q == BUSY && ({pmem_read, pmem_write} != ops_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pmem_error = err_q;
`endif

endmodule
